// File: rtl/filter_bank_pkg.sv
// Shared types and helpers for the matched-filter bank sequencer.
// fp32 compare assumes a positive threshold.
package filter_bank_pkg;

  localparam int          N_FILT_DEF = 6;
  localparam int          X_LEN_DEF  = 2048;
  localparam logic [31:0] FP32_1000  = 32'h447A0000;

  typedef logic [63:0] sample_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DECIDE
  } fbc_state_e;

  // Positive fp32 orders like its magnitude bits; NaN never qualifies
  function automatic logic fp32_ge_pos(
    input logic [31:0] x,
    input logic [31:0] th
  );
    logic nan;
    nan = (&x[30:23]) && (|x[22:0]);
    return !x[31] && !nan && (x[30:0] >= th[30:0]);
  endfunction

endpackage

// File: rtl/filter_bank_ctrl_if.sv
// Filter-side bus of the sequencer: start handshakes, broadcast
// sample FIFO port and per-filter result collection.
interface filter_bank_ctrl_if
  import filter_bank_pkg::*;
#(
  parameter int N_FILT = N_FILT_DEF
);

  logic [N_FILT-1:0]    f_start;
  logic [N_FILT-1:0]    f_ready;
  logic [N_FILT-1:0]    f_done;
  sample_t              f_x_dout;
  logic [N_FILT-1:0]    f_x_empty_n;
  logic [N_FILT-1:0]    f_x_read;
  logic [N_FILT*32-1:0] f_max;
  logic [N_FILT-1:0]    f_max_vld;

  modport master (
    output f_start,
    output f_x_dout,
    output f_x_empty_n,
    input  f_ready,
    input  f_done,
    input  f_x_read,
    input  f_max,
    input  f_max_vld
  );

  modport slave (
    input  f_start,
    input  f_x_dout,
    input  f_x_empty_n,
    output f_ready,
    output f_done,
    output f_x_read,
    output f_max,
    output f_max_vld
  );

endinterface

// File: rtl/filter_bank_ctrl_bcast_reg.sv
// One-entry fan-out register: each filter takes the held sample once,
// the entry frees when every filter has taken it.
module bcast_reg
  import filter_bank_pkg::*;
#(
  parameter int N = N_FILT_DEF
) (
  input  logic         ap_clk,
  input  logic         ap_rst,
  input  logic         load,
  input  sample_t      din,
  input  logic [N-1:0] rd,
  output sample_t      dout,
  output logic [N-1:0] empty_n,
  output logic         hold_valid,
  output logic         frees
);

  logic [N-1:0] taken_q;
  logic [N-1:0] taken_d;

  // This cycle's reads count toward freeing the entry
  always_comb begin
    empty_n = {N{hold_valid}} & ~taken_q;
    taken_d = taken_q | (rd & empty_n);
    frees   = hold_valid & (&taken_d);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      hold_valid <= 1'b0;
      taken_q    <= '0;
      dout       <= '0;
    end else if (load) begin
      dout       <= din;
      hold_valid <= 1'b1;
      taken_q    <= '0;
    end else if (frees) begin
      hold_valid <= 1'b0;
      taken_q    <= '0;
    end else begin
      taken_q    <= taken_d;
    end
  end

endmodule

// File: rtl/filter_bank_ctrl.sv
// Matched-filter bank sequencer: starts all filters, broadcasts one
// frame, collects maxima and resolves the detection index.
module filter_bank_ctrl
  import filter_bank_pkg::*;
#(
  parameter int          N_FILT  = N_FILT_DEF,
  parameter int          X_LEN   = X_LEN_DEF,
  parameter logic [31:0] THRESH  = FP32_1000,
  parameter int          TIMEOUT = 65536
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  input  sample_t            s_data,
  input  logic               s_valid,
  output logic               s_ready,
  filter_bank_ctrl_if.master fb,
  output logic [2:0]         zhzq,
  output logic               zhzq_vld
);

  localparam int CW = $clog2(X_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] XL_C    = CW'(X_LEN);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  fbc_state_e state_q;
  fbc_state_e state_d;

  logic [CW-1:0]     ld_cnt;
  logic [TW-1:0]     to_cnt;
  logic [N_FILT-1:0] started;
  logic [N_FILT-1:0] done_m;
  logic [N_FILT-1:0] cap_m;
  logic [31:0]       max_r [N_FILT];

  logic       hold_valid;
  logic       frees;
  logic       load;
  logic       timed_out;
  logic       collect;
  logic [2:0] zhzq_d;
  logic       vld_d;

  bcast_reg #(
    .N (N_FILT)
  ) u_bcast (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .load       (load),
    .din        (s_data),
    .rd         (fb.f_x_read),
    .dout       (fb.f_x_dout),
    .empty_n    (fb.f_x_empty_n),
    .hold_valid (hold_valid),
    .frees      (frees)
  );

  assign busy      = (state_q != S_IDLE);
  assign timed_out = (to_cnt == TO_LAST);
  assign collect   = (state_q == S_RUN) ||
                     (state_q == S_DRAIN);

  always_comb begin
    state_d    = state_q;
    s_ready    = 1'b0;
    load       = 1'b0;
    fb.f_start = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        fb.f_start = ~started;
        s_ready    = (ld_cnt != XL_C) &&
                     (!hold_valid || frees);
        load       = s_ready && s_valid;
        if (ld_cnt == XL_C && !hold_valid && &started)
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (&done_m || timed_out) state_d = S_DECIDE;
      end
      S_DECIDE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Lowest captured index over threshold wins; last filter is not scanned
  always_comb begin
    zhzq_d = '0;
    vld_d  = 1'b0;
    for (int j = N_FILT - 2; j >= 0; j--) begin
      if (cap_m[j] && fp32_ge_pos(max_r[j], THRESH)) begin
        zhzq_d = 3'(N_FILT - 1 - j);
        vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q  <= S_IDLE;
      ld_cnt   <= '0;
      to_cnt   <= '0;
      started  <= '0;
      done_m   <= '0;
      cap_m    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      zhzq     <= '0;
      zhzq_vld <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      if (state_q == S_IDLE && start) begin
        ld_cnt  <= '0;
        to_cnt  <= '0;
        started <= '0;
        done_m  <= '0;
        cap_m   <= '0;
      end
      if (load) ld_cnt <= ld_cnt + 1'b1;
      if (state_q == S_RUN)
        started <= started | (fb.f_start & fb.f_ready);
      if (collect) begin
        done_m <= done_m | fb.f_done;
        cap_m  <= cap_m | fb.f_max_vld;
      end
      if (state_q == S_DRAIN) to_cnt <= to_cnt + 1'b1;
      if (state_q == S_DECIDE) begin
        done     <= 1'b1;
        err      <= ~&done_m;
        zhzq     <= zhzq_d;
        zhzq_vld <= vld_d;
      end
    end
  end

  // Only the first reported maximum per frame is kept
  always_ff @(posedge ap_clk) begin
    for (int i = 0; i < N_FILT; i++) begin
      if (collect && fb.f_max_vld[i] && !cap_m[i])
        max_r[i] <= fb.f_max[32*i +: 32];
    end
  end

endmodule

// File: tb/tb_filter_bank_ctrl.sv
// Directed bench for filter_bank_ctrl with behavioural filter models.
// Hand-computed detection results per frame.
module tb_filter_bank_ctrl;
  import filter_bank_pkg::*;

  localparam int NF = 6;
  localparam int XL = 2048;

  localparam logic [31:0] F0     = 32'h00000000;
  localparam logic [31:0] F500   = 32'h43FA0000;
  localparam logic [31:0] F999   = 32'h4479F99A;
  localparam logic [31:0] F1000  = 32'h447A0000;
  localparam logic [31:0] F1200  = 32'h44960000;
  localparam logic [31:0] F2000  = 32'h44FA0000;
  localparam logic [31:0] F5000  = 32'h459C4000;
  localparam logic [31:0] FNAN   = 32'h7FC00000;
  localparam logic [31:0] FINF   = 32'h7F800000;
  localparam logic [31:0] FM1000 = 32'hC47A0000;

  logic       ap_clk = 1'b0;
  logic       ap_rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, err;
  sample_t    s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [2:0] zhzq;
  logic       zhzq_vld;

  filter_bank_ctrl_if #(.N_FILT(NF)) fb();

  filter_bank_ctrl #(
    .N_FILT  (NF),
    .X_LEN   (XL),
    .THRESH  (F1000),
    .TIMEOUT (100)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .fb       (fb),
    .zhzq     (zhzq),
    .zhzq_vld (zhzq_vld)
  );

  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int          rx_cnt [NF];
  int          gap [NF];
  int          dcnt [NF];
  logic [31:0] fmax_cfg [NF];
  logic [NF-1:0] no_done = '0;
  int  slow_f = -1;
  bit  src_en = 0, mdl_en = 0, acc_pend = 0;
  int  src_idx = 0, src_base = 0;
  int  acc_cnt = 0, acc_first = 0, acc_last = 0;
  int  seq_err = 0, last_rd = 0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  function automatic sample_t mk(input int k);
    return {32'(k) ^ 32'h3C000000, 32'(k * 7 + 1)};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Source and filter models act on the falling edge
  always @(negedge ap_clk) begin
    logic [NF-1:0] rd;
    logic [NF-1:0] fd;
    rd = '0;
    fd = '0;
    if (acc_pend) begin
      src_idx++;
      acc_pend = 0;
    end
    s_valid = src_en && (src_idx < XL + 4);
    s_data  = s_valid ? mk(src_base + src_idx) : '0;
    if (mdl_en) begin
      fb.f_ready = fb.f_start;
      for (int i = 0; i < NF; i++) begin
        if (dcnt[i] > 0) begin
          dcnt[i]--;
          if (dcnt[i] == 0 && !no_done[i]) fd[i] = 1'b1;
        end
        if (gap[i] > 0) gap[i]--;
        else if (fb.f_x_empty_n[i]) begin
          rd[i] = 1'b1;
          if (fb.f_x_dout !== mk(src_base + rx_cnt[i]))
            seq_err++;
          rx_cnt[i]++;
          last_rd = cyc;
          if (rx_cnt[i] == XL) dcnt[i] = 10;
          if (i == slow_f) gap[i] = 2;
        end
      end
    end else begin
      fb.f_ready = '0;
    end
    fb.f_x_read  = rd;
    fb.f_done    = fd;
    fb.f_max_vld = fd;
    for (int i = 0; i < NF; i++)
      fb.f_max[32*i +: 32] = fmax_cfg[i];
    #1;
    if (s_valid && s_ready) begin
      acc_pend = 1;
      if (acc_cnt == 0) acc_first = cyc;
      acc_cnt++;
      acc_last = cyc;
    end
  end

  task automatic step();
    @(posedge ap_clk);
    #2;
  endtask

  task automatic new_frame(input int base);
    src_idx = 0; acc_pend = 0; acc_cnt = 0;
    acc_first = 0; acc_last = 0; seq_err = 0;
    src_base = base;
    for (int i = 0; i < NF; i++) begin
      rx_cnt[i] = 0; gap[i] = 0; dcnt[i] = 0;
    end
    src_en = 1; mdl_en = 1;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int n);
    n = 0;
    while (done !== 1'b1 && n < lim) begin
      step();
      n++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic set_max(input logic [31:0] m0, m1, m2,
                         input logic [31:0] m3, m4, m5);
    fmax_cfg[0] = m0; fmax_cfg[1] = m1; fmax_cfg[2] = m2;
    fmax_cfg[3] = m3; fmax_cfg[4] = m4; fmax_cfg[5] = m5;
  endtask

  initial begin
    int n;
    int d;
    fb.f_ready = '0; fb.f_done = '0; fb.f_x_read = '0;
    fb.f_max = '0; fb.f_max_vld = '0;
    set_max(F0, F0, F0, F0, F0, F0);
    for (int i = 0; i < NF; i++) begin
      rx_cnt[i] = 0; gap[i] = 0; dcnt[i] = 0;
    end
    repeat (3) step();
    chk("rst_outs", {busy, done, err, zhzq_vld, zhzq, s_ready,
                     fb.f_start, fb.f_x_empty_n}, 0);
    chk("rst_dout", fb.f_x_dout, 0);
    ap_rst = 1'b0;
    step();

    // Frame 1: ideal filters, second channel over threshold
    set_max(F500, F1200, F2000, F0, F0, F0);
    new_frame(0);
    chk("t1_fstart", fb.f_start, 6'h3F);
    chk("t1_busy", busy, 1);
    wait_done(5000, n);
    chk("t1_zhzq", zhzq, 4);
    chk("t1_vld", zhzq_vld, 1);
    chk("t1_err", err, 0);
    chk("t1_seq", seq_err, 0);
    chk("t1_rx0", rx_cnt[0], XL);
    chk("t1_rx5", rx_cnt[5], XL);
    chk("t1_acc", acc_cnt, XL);
    chk("t1_sready_run", acc_last - acc_first + 1, XL);
    step();
    chk("t1_done_pulse", done, 0);
    chk("t1_idle", busy, 0);

    // Frame 2: only the unscanned last filter is above threshold
    set_max(F999, F999, F999, F999, F999, F5000);
    new_frame(10000);
    wait_done(5000, n);
    chk("t2_zhzq", zhzq, 0);
    chk("t2_vld", zhzq_vld, 0);
    chk("t2_err", err, 0);

    // Frame 3: filter 3 reads every third cycle
    set_max(F500, F1200, F2000, F0, F0, F0);
    slow_f = 3;
    new_frame(20000);
    wait_done(8000, n);
    slow_f = -1;
    chk("t3_seq", seq_err, 0);
    chk("t3_rx3", rx_cnt[3], XL);
    chk("t3_rx0", rx_cnt[0], XL);
    chk("t3_len", (n >= 6100 && n <= 6300), 1);
    chk("t3_zhzq", zhzq, 4);

    // Frame 4: filter 2 silent, timeout path
    set_max(F500, F999, F2000, F0, F0, F0);
    no_done = 6'b000100;
    new_frame(30000);
    wait_done(5000, n);
    d = cyc - last_rd;
    no_done = '0;
    chk("t4_err", err, 1);
    chk("t4_vld", zhzq_vld, 0);
    chk("t4_zhzq", zhzq, 0);
    chk("t4_lat", (d >= 100 && d <= 106), 1);

    // Frame 5a: +Inf on 0 qualifies, NaN on 1 does not matter
    set_max(FINF, FNAN, F0, F0, F0, F0);
    new_frame(40000);
    wait_done(5000, n);
    chk("t5a_zhzq", zhzq, 5);
    chk("t5a_vld", zhzq_vld, 1);
    chk("t5a_err", err, 0);

    // Frame 5b: negative, NaN skipped, equality qualifies
    set_max(FM1000, FNAN, F1000, F0, F0, F0);
    new_frame(50000);
    wait_done(5000, n);
    chk("t5b_zhzq", zhzq, 3);
    chk("t5b_vld", zhzq_vld, 1);

    // Frame 6: reset at sample 700, then a clean frame
    new_frame(60000);
    n = 0;
    while (acc_cnt < 700 && n < 2000) begin
      step();
      n++;
    end
    chk("t6_reach700", (acc_cnt >= 700), 1);
    ap_rst = 1'b1;
    src_en = 0;
    mdl_en = 0;
    step();
    ap_rst = 1'b0;
    chk("t6_rst_outs", {busy, done, err, zhzq_vld, zhzq, s_ready,
                        fb.f_start, fb.f_x_empty_n}, 0);
    chk("t6_rst_dout", fb.f_x_dout, 0);
    step();
    new_frame(70000);
    repeat (50) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(5000, n);
    chk("t6_seq", seq_err, 0);
    chk("t6_rx0", rx_cnt[0], XL);
    chk("t6_acc", acc_cnt, XL);
    chk("t6_zhzq", zhzq, 3);
    chk("t6_vld", zhzq_vld, 1);
    repeat (3) step();
    chk("t6_no_restart", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
